// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - pipeline memory stage: data-cache access sequencing, flush, halt and writeback register
module memory_stage #(
    parameter int CNT_W = 16
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [31:0]      iExuResult,
    input  logic [31:0]      iMemData,
    input  logic             iMemValid,
    input  logic             iMemWrite,
    input  logic             iMemToReg,
    input  logic             iCacheFlush,
    input  logic             iHalt,
    input  logic [4:0]       iWriteAddr,
    input  logic             iWriteEn,
    input  logic [31:0]      iDcRdata,
    input  logic             iDcReady,
    output logic [31:0]      oDcAddr,
    output logic [31:0]      oDcWdata,
    output logic             oDcRe,
    output logic             oDcWe,
    output logic             oDcFlush,
    output logic             oStall,
    output logic [31:0]      oWbData,
    output logic [4:0]       oWbAddr,
    output logic             oWbEn,
    output logic             oHalt,
    output logic [CNT_W-1:0] oAccessCnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_FLUSH  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0]      r_dc_addr;
    logic [31:0]      r_dc_wdata;
    logic             r_dc_re;
    logic             r_dc_we;
    logic             r_dc_flush;
    logic [31:0]      r_wb_data;
    logic [4:0]       r_wb_addr;
    logic             r_wb_en;
    logic             r_halt;
    logic [CNT_W-1:0] r_cnt;

    // Decoded events for the current cycle; flush beats a memory op, both beat halt.
    logic w_idle;
    logic w_launch;
    logic w_flush_go;
    logic w_halt_go;
    logic w_pass;
    logic w_acc_done;

    assign w_idle     = (r_state == S_IDLE);
    assign w_flush_go = w_idle & iCacheFlush;
    assign w_launch   = w_idle & ~iCacheFlush & iMemValid;
    assign w_halt_go  = w_idle & ~iCacheFlush & ~iMemValid & iHalt;
    assign w_pass     = w_idle & ~iCacheFlush & ~iMemValid & ~iHalt;
    assign w_acc_done = (r_state == S_ACCESS) & iDcReady;

    // State register; reset aborts any outstanding access or flush.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; HALTED is left only through reset.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (iCacheFlush) begin
                    w_next = S_FLUSH;
                end else if (iMemValid) begin
                    w_next = S_ACCESS;
                end else if (iHalt) begin
                    w_next = S_HALTED;
                end
            end
            S_ACCESS: if (iDcReady) w_next = S_IDLE;
            S_FLUSH:  if (iDcReady) w_next = S_IDLE;
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_IDLE;
        endcase
    end

    // Combinational stall toward the upstream stages.
    always_comb begin
        oStall = 1'b0;
        unique case (r_state)
            S_IDLE:   oStall = iMemValid | iCacheFlush;
            S_ACCESS: oStall = ~iDcReady;
            S_FLUSH:  oStall = ~iDcReady;
            S_HALTED: oStall = 1'b1;
            default:  oStall = 1'b0;
        endcase
    end

    // Cache request pulses, launch address/data, writeback register, halt flag and access counter.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_dc_addr  <= '0;
            r_dc_wdata <= '0;
            r_dc_re    <= 1'b0;
            r_dc_we    <= 1'b0;
            r_dc_flush <= 1'b0;
            r_wb_data  <= '0;
            r_wb_addr  <= '0;
            r_wb_en    <= 1'b0;
            r_halt     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            // Pulses are only raised on the edge leaving IDLE, so they last exactly one cycle.
            r_dc_re    <= w_launch & ~iMemWrite;
            r_dc_we    <= w_launch & iMemWrite;
            r_dc_flush <= w_flush_go;
            if (w_launch) begin
                r_dc_addr  <= iExuResult;
                r_dc_wdata <= iMemData;
            end
            if (w_pass) begin
                r_wb_data <= iExuResult;
                r_wb_addr <= iWriteAddr;
                r_wb_en   <= iWriteEn;
            end else if (w_acc_done) begin
                r_wb_data <= iMemToReg ? iDcRdata : iExuResult;
                r_wb_addr <= iWriteAddr;
                r_wb_en   <= iWriteEn & ~iMemWrite;
            end else begin
                r_wb_en   <= 1'b0;
            end
            if (w_halt_go) begin
                r_halt <= 1'b1;
            end
            if (w_acc_done && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign oDcAddr    = r_dc_addr;
    assign oDcWdata   = r_dc_wdata;
    assign oDcRe      = r_dc_re;
    assign oDcWe      = r_dc_we;
    assign oDcFlush   = r_dc_flush;
    assign oWbData    = r_wb_data;
    assign oWbAddr    = r_wb_addr;
    assign oWbEn      = r_wb_en;
    assign oHalt      = r_halt;
    assign oAccessCnt = r_cnt;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized self-checking bench for memory_stage against a transaction-level model
module tb_memory_stage;

    localparam int CW     = 2;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          iClk = 1'b0;
    logic          iRst = 1'b0;
    logic [31:0]   iExuResult = '0;
    logic [31:0]   iMemData = '0;
    logic          iMemValid = 1'b0;
    logic          iMemWrite = 1'b0;
    logic          iMemToReg = 1'b0;
    logic          iCacheFlush = 1'b0;
    logic          iHalt = 1'b0;
    logic [4:0]    iWriteAddr = '0;
    logic          iWriteEn = 1'b0;
    logic [31:0]   iDcRdata = '0;
    logic          iDcReady = 1'b0;
    logic [31:0]   oDcAddr;
    logic [31:0]   oDcWdata;
    logic          oDcRe;
    logic          oDcWe;
    logic          oDcFlush;
    logic          oStall;
    logic [31:0]   oWbData;
    logic [4:0]    oWbAddr;
    logic          oWbEn;
    logic          oHalt;
    logic [CW-1:0] oAccessCnt;

    int n_vec = 0;
    int n_err = 0;
    int m_cnt = 0;

    memory_stage #(.CNT_W(CW)) dut (
        .iClk(iClk), .iRst(iRst), .iExuResult(iExuResult), .iMemData(iMemData),
        .iMemValid(iMemValid), .iMemWrite(iMemWrite), .iMemToReg(iMemToReg),
        .iCacheFlush(iCacheFlush), .iHalt(iHalt), .iWriteAddr(iWriteAddr),
        .iWriteEn(iWriteEn), .iDcRdata(iDcRdata), .iDcReady(iDcReady),
        .oDcAddr(oDcAddr), .oDcWdata(oDcWdata), .oDcRe(oDcRe), .oDcWe(oDcWe),
        .oDcFlush(oDcFlush), .oStall(oStall), .oWbData(oWbData), .oWbAddr(oWbAddr),
        .oWbEn(oWbEn), .oHalt(oHalt), .oAccessCnt(oAccessCnt)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_inputs();
        iMemValid   = 1'b0;
        iMemWrite   = 1'b0;
        iMemToReg   = 1'b0;
        iCacheFlush = 1'b0;
        iHalt       = 1'b0;
        iDcReady    = 1'b0;
        iWriteEn    = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wbdata"}, oWbData, 32'd0);
        chk({tag, "_wbaddr"}, 32'(oWbAddr), 32'd0);
        chk({tag, "_wben"}, 32'(oWbEn), 32'd0);
        chk({tag, "_halt"}, 32'(oHalt), 32'd0);
        chk({tag, "_cnt"}, 32'(oAccessCnt), 32'd0);
        chk({tag, "_dcaddr"}, oDcAddr, 32'd0);
        chk({tag, "_dcwdata"}, oDcWdata, 32'd0);
        chk({tag, "_req"}, {29'd0, oDcRe, oDcWe, oDcFlush}, 32'd0);
    endtask

    // Non-memory instruction: result passes to writeback one edge later; cache ready is irrelevant.
    task automatic alu_op(input logic [31:0] exu, input logic [4:0] wa, input logic we);
        idle_inputs();
        iExuResult = exu;
        iWriteAddr = wa;
        iWriteEn   = we;
        iMemData   = $urandom;
        iMemWrite  = 1'($urandom);
        iMemToReg  = 1'($urandom);
        iDcReady   = 1'($urandom);
        iDcRdata   = $urandom;
        @(negedge iClk);
        chk("alu_stall", 32'(oStall), 32'd0);
        chk("alu_req", {29'd0, oDcRe, oDcWe, oDcFlush}, 32'd0);
        next_cyc();
        chk("alu_wbdata", oWbData, exu);
        chk("alu_wbaddr", 32'(oWbAddr), 32'(wa));
        chk("alu_wben", 32'(oWbEn), 32'(we));
        chk("alu_cnt", 32'(oAccessCnt), 32'(m_cnt));
    endtask

    // Load or store completing in the lat-th cycle after launch.
    task automatic mem_op(input logic wr, input logic mtr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input logic [4:0] wa, input logic we, input int lat);
        idle_inputs();
        iMemValid  = 1'b1;
        iMemWrite  = wr;
        iMemToReg  = mtr;
        iExuResult = addr;
        iMemData   = wdata;
        iWriteAddr = wa;
        iWriteEn   = we;
        iDcRdata   = $urandom;
        @(negedge iClk);
        chk("mem_launch_stall", 32'(oStall), 32'd1);
        chk("mem_launch_req", {29'd0, oDcRe, oDcWe, oDcFlush}, 32'd0);
        for (int k = 1; k <= lat; k++) begin
            next_cyc();
            iDcReady = (k == lat);
            iDcRdata = (k == lat) ? rdata : $urandom;
            @(negedge iClk);
            chk("mem_stall", 32'(oStall), 32'(k != lat));
            chk("mem_re", 32'(oDcRe), 32'((k == 1) && !wr));
            chk("mem_we", 32'(oDcWe), 32'((k == 1) && wr));
            chk("mem_flush", 32'(oDcFlush), 32'd0);
            chk("mem_addr", oDcAddr, addr);
            chk("mem_wdata", oDcWdata, wdata);
            chk("mem_bubble", 32'(oWbEn), 32'd0);
        end
        next_cyc();
        if (m_cnt < CNTMAX) m_cnt++;
        chk("mem_wbdata", oWbData, mtr ? rdata : addr);
        chk("mem_wbaddr", 32'(oWbAddr), 32'(wa));
        chk("mem_wben", 32'(oWbEn), 32'(we && !wr));
        chk("mem_cnt", 32'(oAccessCnt), 32'(m_cnt));
        chk("mem_pulse_gone", {29'd0, oDcRe, oDcWe, oDcFlush}, 32'd0);
        idle_inputs();
    endtask

    // Flush, optionally colliding with a memory request which must be ignored.
    task automatic flush_op(input int lat, input logic mv);
        idle_inputs();
        iCacheFlush = 1'b1;
        iMemValid   = mv;
        iMemWrite   = 1'($urandom);
        iExuResult  = $urandom;
        iWriteEn    = 1'b1;
        @(negedge iClk);
        chk("fl_launch_stall", 32'(oStall), 32'd1);
        for (int k = 1; k <= lat; k++) begin
            next_cyc();
            iDcReady = (k == lat);
            @(negedge iClk);
            chk("fl_stall", 32'(oStall), 32'(k != lat));
            chk("fl_pulse", 32'(oDcFlush), 32'(k == 1));
            chk("fl_rw", {30'd0, oDcRe, oDcWe}, 32'd0);
            chk("fl_bubble", 32'(oWbEn), 32'd0);
        end
        next_cyc();
        chk("fl_wben", 32'(oWbEn), 32'd0);
        chk("fl_cnt", 32'(oAccessCnt), 32'(m_cnt));
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        #1 iRst = 1'b1;
        #11;
        chk_all_zero("reset");
        chk("reset_stall", 32'(oStall), 32'd0);
        iRst = 1'b0;
        m_cnt = 0;
        next_cyc();

        alu_op(32'h1234, 5'd3, 1'b1);
        mem_op(1'b0, 1'b1, 32'h100, 32'h0, 32'hCAFEBABE, 5'd5, 1'b1, 2);
        mem_op(1'b1, 1'b0, 32'h200, 32'h55, 32'h0, 5'd6, 1'b1, 1);
        flush_op(2, 1'b1);
        for (int i = 0; i < 5; i++)
            mem_op(1'b0, 1'b1, 32'h300 + 32'(i), 32'h0, $urandom, 5'd7, 1'b1, 1 + (i % 3));
        chk("sat_cnt", 32'(oAccessCnt), 32'(CNTMAX));

        for (int i = 0; i < 150; i++) begin
            case ($urandom % 4)
                0: alu_op($urandom, 5'($urandom), 1'($urandom));
                1: mem_op(1'b0, 1'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom_range(1, 4));
                2: mem_op(1'b1, 1'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom_range(1, 4));
                default: flush_op($urandom_range(1, 4), 1'($urandom));
            endcase
        end

        // Reset in the middle of a load: pulse and launch state drop at once.
        idle_inputs();
        iMemValid  = 1'b1;
        iExuResult = 32'hABC;
        iWriteEn   = 1'b1;
        next_cyc();
        #2;
        chk("abort_pre_re", 32'(oDcRe), 32'd1);
        iRst      = 1'b1;
        iMemValid = 1'b0;
        #1;
        chk_all_zero("abort");
        m_cnt = 0;
        @(negedge iClk);
        iRst = 1'b0;
        next_cyc();
        for (int i = 0; i < 3; i++) alu_op($urandom, 5'($urandom), 1'b1);
        chk("late_ready_cnt", 32'(oAccessCnt), 32'd0);
        mem_op(1'b0, 1'b0, 32'h444, 32'h0, 32'h0, 5'd9, 1'b1, 3);

        // Halt: sticky stall and flag, no requests whatever the inputs do.
        idle_inputs();
        iHalt = 1'b1;
        @(negedge iClk);
        chk("halt_entry_stall", 32'(oStall), 32'd0);
        next_cyc();
        chk("halt_flag", 32'(oHalt), 32'd1);
        for (int i = 0; i < 6; i++) begin
            iHalt       = 1'($urandom);
            iMemValid   = 1'($urandom);
            iCacheFlush = 1'($urandom);
            iDcReady    = 1'($urandom);
            iWriteEn    = 1'b1;
            @(negedge iClk);
            chk("halted_stall", 32'(oStall), 32'd1);
            chk("halted_flag", 32'(oHalt), 32'd1);
            chk("halted_req", {29'd0, oDcRe, oDcWe, oDcFlush}, 32'd0);
            chk("halted_wben", 32'(oWbEn), 32'd0);
            next_cyc();
        end
        idle_inputs();
        #2 iRst = 1'b1;
        #1;
        chk_all_zero("halt_rst");
        chk("halt_rst_stall", 32'(oStall), 32'd0);
        m_cnt = 0;
        @(negedge iClk);
        iRst = 1'b0;
        next_cyc();
        alu_op(32'h5A5A, 5'd1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
